// File: rtl/abort_drop_fifo.sv
// abort_drop_fifo
// ---------------
// Store-and-forward packet buffer. Each incoming packet is written into a
// circular buffer and only becomes visible to the read side once its LAST
// beat has been accepted. A packet cut short by S_ABORT, or one that does not
// fit, is rewound and never reaches the output. Downstream logic therefore
// sees only complete packets, with no aborts.
//
// Ports
//   S_CLK, S_RESET     clock, synchronous active-high reset
//   S_VALID/S_READY    input handshake (S_READY is 1 outside reset)
//   S_DATA, S_BYTES    input beat data, valid bytes in last beat (0 = full)
//   S_ABORT, S_LAST    abort current packet / final beat of packet
//   M_VALID/M_READY    output handshake
//   M_DATA, M_BYTES    output beat data, byte count
//   M_LAST             output last beat
//   o_drop             1-cycle pulse: packet discarded because of S_ABORT
//   o_overflow         1-cycle pulse: packet discarded because buffer was full
//
// Parameters
//   DW            bits per beat (power of two, >= 16)
//   LGFLEN        log2 of buffer depth; usable capacity is 2^LGFLEN-1 beats
//   OPT_LOWPOWER  force M_DATA/M_BYTES/M_LAST to zero while M_VALID is low
module abort_drop_fifo #(
  parameter int DW           = 32,
  parameter int LGFLEN       = 10,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic                    S_CLK,
  input  logic                    S_RESET,
  input  logic                    S_VALID,
  output logic                    S_READY,
  input  logic [DW-1:0]           S_DATA,
  input  logic [$clog2(DW/8)-1:0] S_BYTES,
  input  logic                    S_ABORT,
  input  logic                    S_LAST,
  output logic                    M_VALID,
  input  logic                    M_READY,
  output logic [DW-1:0]           M_DATA,
  output logic [$clog2(DW/8)-1:0] M_BYTES,
  output logic                    M_LAST,
  output logic                    o_drop,
  output logic                    o_overflow
);

  localparam int BW    = $clog2(DW/8);
  localparam int MW    = DW + BW + 1;
  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN-1:0] ONE = 1;

  // Write-side packet state:
  //   W_IDLE  between packets (midpacket=0, dropping=0)
  //   W_MID   at least one beat of the current packet is buffered
  //   W_DROP  discarding the rest of a packet that overflowed
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_MID  = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  wstate_t state, state_nxt;

  logic [MW-1:0]     mem [0:DEPTH-1];
  logic [LGFLEN-1:0] wr_addr, wr_commit, rd_addr;
  logic [LGFLEN-1:0] wr_addr_nxt, wr_commit_nxt;
  logic              wr_en;
  logic              drop_nxt, ovf_nxt;
  logic              full;
  logic              avail;
  logic              load;
  logic [MW-1:0]     out_word;

  assign S_READY = !S_RESET;

  // One slot is always left empty so that full and empty are distinguishable
  // from the pointers alone. rd_addr already points past the beat held in the
  // output register, so that beat does not count against capacity.
  assign full = ((wr_addr + ONE) == rd_addr);

  // ------------------------------------------------------------------
  // Write path: next-state and pointer decisions
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    wr_addr_nxt   = wr_addr;
    wr_commit_nxt = wr_commit;
    wr_en         = 1'b0;
    drop_nxt      = 1'b0;
    ovf_nxt       = 1'b0;

    if (S_ABORT) begin
      // Abort takes priority over any beat presented in the same cycle,
      // including a LAST beat: nothing is written or committed.
      case (state)
        W_MID: begin
          wr_addr_nxt = wr_commit;
          drop_nxt    = 1'b1;
          state_nxt   = W_IDLE;
        end
        W_DROP: state_nxt = W_IDLE;
        default: state_nxt = W_IDLE;
      endcase
    end else if (S_VALID) begin
      if (state == W_DROP) begin
        // Swallow the remainder of the overflowed packet.
        if (S_LAST)
          state_nxt = W_IDLE;
      end else if (full) begin
        // Rewind to the last committed boundary. A single LAST beat that
        // does not fit ends the packet on its own, so no drop phase follows.
        wr_addr_nxt = wr_commit;
        ovf_nxt     = 1'b1;
        state_nxt   = S_LAST ? W_IDLE : W_DROP;
      end else begin
        wr_en       = 1'b1;
        wr_addr_nxt = wr_addr + ONE;
        if (S_LAST) begin
          wr_commit_nxt = wr_addr + ONE;
          state_nxt     = W_IDLE;
        end else begin
          state_nxt     = W_MID;
        end
      end
    end
  end

  always_ff @(posedge S_CLK) begin
    if (S_RESET) begin
      state      <= W_IDLE;
      wr_addr    <= '0;
      wr_commit  <= '0;
      o_drop     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_commit  <= wr_commit_nxt;
      o_drop     <= drop_nxt;
      o_overflow <= ovf_nxt;
    end
  end

  // Storage has no reset so it can map onto block RAM; pointers alone define
  // what is valid.
  always_ff @(posedge S_CLK) begin
    if (wr_en && !S_RESET)
      mem[wr_addr] <= {S_LAST, S_BYTES, S_DATA};
  end

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  // Only committed beats are readable. Because reads stay strictly behind
  // wr_commit, the read address never collides with the write address.
  assign avail = (rd_addr != wr_commit);
  assign load  = (!M_VALID || M_READY) && avail;

  always_ff @(posedge S_CLK) begin
    if (S_RESET) begin
      M_VALID <= 1'b0;
      rd_addr <= '0;
    end else if (load) begin
      M_VALID <= 1'b1;
      rd_addr <= rd_addr + ONE;
    end else if (M_READY) begin
      M_VALID <= 1'b0;
    end
  end

  // Output data register doubles as the RAM's registered read port.
  always_ff @(posedge S_CLK) begin
    if (S_RESET) begin
      if (OPT_LOWPOWER)
        out_word <= '0;
    end else if (load) begin
      out_word <= mem[rd_addr];
    end else if (OPT_LOWPOWER && M_READY) begin
      out_word <= '0;
    end
  end

  assign {M_LAST, M_BYTES, M_DATA} = out_word;

endmodule
